// File: rtl/pulse_symbol_sequencer.sv
// pulse_symbol_sequencer
// Walks a CPU-written 1-bit symbol memory from start_idx to end_idx (inclusive,
// wrapping 127->0) and turns each symbol into a high phase followed by a low
// phase, both counted in prescaler ticks. The envelope gates the carrier in
// the downstream output stage.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   tick                 prescaler strobe; phase counters decrement only on tick
//   mem_we/addr/wdata    symbol memory word write (symbol i = word[i[6:5]][i[4:0]])
//   start                level enable: rising edge launches, low aborts
//   loop                 restart at start_idx after end_idx instead of stopping
//   start_idx, end_idx   first / last (inclusive) symbol index
//   high_dur_a/low_dur_a phase lengths for symbol 0
//   high_dur_b/low_dur_b phase lengths for symbol 1
//   envelope             modulation envelope
//   busy                 sequencer not idle
//   symbol_idx           current program counter
//   done                 one-cycle pulse on normal completion
//   wrap                 one-cycle pulse on each loop restart
module pulse_symbol_sequencer #(
    parameter int NUM_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        mem_we,
    input  logic [1:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        start,
    input  logic        loop,
    input  logic [6:0]  start_idx,
    input  logic [6:0]  end_idx,
    input  logic [7:0]  high_dur_a,
    input  logic [7:0]  low_dur_a,
    input  logic [7:0]  high_dur_b,
    input  logic [7:0]  low_dur_b,
    output logic        envelope,
    output logic        busy,
    output logic [6:0]  symbol_idx,
    output logic        done,
    output logic        wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [6:0]  idx, idx_n;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  lat_low, lat_low_n;
    logic        start_q;
    logic        done_n, wrap_n;
    logic        launch;
    logic        mem_bit;

    // Symbol memory, no reset. The combinational read below sees the
    // pre-edge contents, so a write landing on the LOAD edge returns old data.
    logic [31:0] mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_bit = mem[idx[6:5]][idx[4:0]];
    assign launch  = start & ~start_q;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        lat_low_n = lat_low;
        done_n    = 1'b0;
        wrap_n    = 1'b0;

        if (!start) begin
            // Abort wins over every transition; idx is left where it was.
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        idx_n   = start_idx;
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    // Both durations are captured here so mid-symbol changes
                    // only affect the next symbol.
                    cnt_n     = mem_bit ? high_dur_b : high_dur_a;
                    lat_low_n = mem_bit ? low_dur_b  : low_dur_a;
                    state_n   = HIGH;
                end
                HIGH: begin
                    if (cnt == 8'd0) begin
                        cnt_n   = lat_low;
                        state_n = LOW;
                    end else if (tick) begin
                        cnt_n = cnt - 8'd1;
                    end
                end
                LOW: begin
                    if (cnt == 8'd0) begin
                        if (idx == end_idx) begin
                            if (loop) begin
                                idx_n   = start_idx;
                                wrap_n  = 1'b1;
                                state_n = LOAD;
                            end else begin
                                done_n  = 1'b1;
                                state_n = IDLE;
                            end
                        end else begin
                            // 7-bit add wraps 127 -> 0 for start_idx > end_idx runs
                            idx_n   = idx + 7'd1;
                            state_n = LOAD;
                        end
                    end else if (tick) begin
                        cnt_n = cnt - 8'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 7'd0;
            cnt     <= 8'd0;
            lat_low <= 8'd0;
            start_q <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            lat_low <= lat_low_n;
            start_q <= start;
            done    <= done_n;
            wrap    <= wrap_n;
        end
    end

    // A zero-length high phase still spends one cycle in HIGH, so the
    // envelope also requires a non-zero count.
    assign envelope   = (state == HIGH) && (cnt != 8'd0);
    assign busy       = (state != IDLE);
    assign symbol_idx = idx;

endmodule

// File: tb/tb_pulse_symbol_sequencer.sv
// Directed bench for pulse_symbol_sequencer. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge. Sample k=0 is
// the cycle right after the launch edge (state LOAD).
module tb_pulse_symbol_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_addr = 2'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        start = 1'b0;
    logic        loop = 1'b0;
    logic [6:0]  start_idx = 7'd0;
    logic [6:0]  end_idx = 7'd0;
    logic [7:0]  high_dur_a = 8'd0;
    logic [7:0]  low_dur_a = 8'd0;
    logic [7:0]  high_dur_b = 8'd0;
    logic [7:0]  low_dur_b = 8'd0;
    logic        envelope;
    logic        busy;
    logic [6:0]  symbol_idx;
    logic        done;
    logic        wrap;

    int total = 0;
    int bad = 0;
    bit tick_div = 1'b0;
    int cyc = 0;

    pulse_symbol_sequencer #(.NUM_WORDS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .start      (start),
        .loop       (loop),
        .start_idx  (start_idx),
        .end_idx    (end_idx),
        .high_dur_a (high_dur_a),
        .low_dur_a  (low_dur_a),
        .high_dur_b (high_dur_b),
        .low_dur_b  (low_dur_b),
        .envelope   (envelope),
        .busy       (busy),
        .symbol_idx (symbol_idx),
        .done       (done),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // tick is either tied high or pulsed every 4th clock
    always @(negedge clk) begin
        cyc = cyc + 1;
        tick = tick_div ? (cyc % 4 == 0) : 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    // start low for one sampled edge, then high; returns at sample k=0
    task automatic launch();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        step();
    endtask

    task automatic set_durs(input logic [7:0] ha, la, hb, lb);
        high_dur_a = ha; low_dur_a = la; high_dur_b = hb; low_dur_b = lb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (envelope !== 1'b0) begin bad++; $display("FAIL reset_envelope got=%b exp=0", envelope); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (symbol_idx !== 7'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", symbol_idx); end
        total++; if (done !== 1'b0 || wrap !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", done, wrap); end
        @(negedge clk);
        rst_n = 1'b1;
        wr(2'd0, 32'h0000_0002);
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'h0);
    endtask

    task automatic test_basic();
        logic [20:0] env_v, done_v, busy_v;
        env_v = '0; done_v = '0; busy_v = '0;
        set_durs(8'd2, 8'd3, 8'd5, 8'd1);
        start_idx = 7'd0; end_idx = 7'd1; loop = 1'b0;
        launch();
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) step();
            env_v[k] = envelope; done_v[k] = done; busy_v[k] = busy;
            if (k == 9) begin
                total++; if (symbol_idx !== 7'd1) begin bad++; $display("FAIL basic_idx got=%0d exp=1", symbol_idx); end
            end
        end
        // start held high the whole time: no relaunch after done
        total++; if (env_v !== 21'b000000011111000000110) begin bad++; $display("FAIL basic_env got=%b exp=%b", env_v, 21'b000000011111000000110); end
        total++; if (done_v !== 21'h020000) begin bad++; $display("FAIL basic_done got=%h exp=020000", done_v); end
        total++; if (busy_v !== 21'h01FFFF) begin bad++; $display("FAIL basic_busy got=%h exp=01ffff", busy_v); end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_prescale();
        int hi, dn;
        hi = 0; dn = 0;
        set_durs(8'd3, 8'd0, 8'd7, 8'd7);
        start_idx = 7'd0; end_idx = 7'd0; loop = 1'b0;
        @(negedge clk);
        tick_div = 1'b1;
        launch();
        for (int k = 0; k < 60; k++) begin
            if (k > 0) step();
            if (envelope === 1'b1) hi++;
            if (done === 1'b1) dn++;
        end
        total++; if (hi < 9 || hi > 12) begin bad++; $display("FAIL prescale_high got=%0d exp=9..12", hi); end
        total++; if (dn != 1) begin bad++; $display("FAIL prescale_done got=%0d exp=1", dn); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL prescale_busy got=%b exp=0", busy); end
        @(negedge clk);
        tick_div = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_loop();
        logic [6:0] exp_seq [9];
        int wraps, dn;
        exp_seq = '{7'd126, 7'd127, 7'd0, 7'd1, 7'd126, 7'd127, 7'd0, 7'd1, 7'd126};
        wraps = 0; dn = 0;
        set_durs(8'd0, 8'd0, 8'd0, 8'd0);
        start_idx = 7'd126; end_idx = 7'd1; loop = 1'b1;
        launch();
        for (int k = 0; k <= 26; k++) begin
            if (k > 0) step();
            if (wrap === 1'b1) wraps++;
            if (done === 1'b1) dn++;
            if (k % 3 == 0 && k / 3 < 9) begin
                total++;
                if (symbol_idx !== exp_seq[k / 3]) begin
                    bad++; $display("FAIL loop_idx k=%0d got=%0d exp=%0d", k, symbol_idx, exp_seq[k / 3]);
                end
            end
            if (k == 12) begin
                total++; if (wrap !== 1'b1) begin bad++; $display("FAIL loop_wrap_k12 got=%b exp=1", wrap); end
            end
        end
        total++; if (wraps != 2) begin bad++; $display("FAIL loop_wrap_count got=%0d exp=2", wraps); end
        total++; if (dn != 0) begin bad++; $display("FAIL loop_done got=%0d exp=0", dn); end
        @(negedge clk);
        start = 1'b0; loop = 1'b0;
    endtask

    task automatic test_abort();
        int dn;
        dn = 0;
        set_durs(8'd10, 8'd0, 8'd10, 8'd0);
        start_idx = 7'd2; end_idx = 7'd3; loop = 1'b0;
        launch();
        repeat (20) step();
        total++; if (envelope !== 1'b1 || symbol_idx !== 7'd3) begin
            bad++; $display("FAIL abort_pre got=env%b/idx%0d exp=env1/idx3", envelope, symbol_idx);
        end
        @(negedge clk);
        start = 1'b0;
        step();
        total++; if (envelope !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_stop got=env%b/busy%b exp=0/0", envelope, busy);
        end
        total++; if (symbol_idx !== 7'd3) begin bad++; $display("FAIL abort_idx_hold got=%0d exp=3", symbol_idx); end
        for (int k = 0; k < 10; k++) begin
            if (done === 1'b1) dn++;
            step();
        end
        total++; if (dn != 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", dn); end
        launch();
        total++; if (symbol_idx !== 7'd2 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_relaunch got=idx%0d/busy%b exp=idx2/busy1", symbol_idx, busy);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_zero();
        logic [14:0] done_v;
        int hi;
        done_v = '0; hi = 0;
        set_durs(8'd0, 8'd0, 8'd0, 8'd0);
        start_idx = 7'd10; end_idx = 7'd13; loop = 1'b0;
        launch();
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) step();
            done_v[k] = done;
            if (envelope !== 1'b0) hi++;
            if (k == 11) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy11 got=%b exp=1", busy); end
            end
            if (k == 12) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy12 got=%b exp=0", busy); end
            end
        end
        total++; if (hi != 0) begin bad++; $display("FAIL zero_env got=%0d exp=0", hi); end
        total++; if (done_v !== 15'h1000) begin bad++; $display("FAIL zero_done got=%h exp=1000", done_v); end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset_write();
        logic [18:0] env_v, done_v;
        env_v = '0; done_v = '0;
        wr(2'd0, 32'h0000_0002);
        set_durs(8'd2, 8'd3, 8'd5, 8'd1);
        start_idx = 7'd4; end_idx = 7'd5; loop = 1'b0;
        launch();
        repeat (3) step();
        total++; if (busy !== 1'b1 || symbol_idx !== 7'd4) begin
            bad++; $display("FAIL rst_pre got=busy%b/idx%0d exp=1/4", busy, symbol_idx);
        end
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0;
        step();
        total++; if ({envelope, busy, done, wrap} !== 4'b0000 || symbol_idx !== 7'd0) begin
            bad++; $display("FAIL rst_mid got=%b%b%b%b/idx%0d exp=0000/0", envelope, busy, done, wrap, symbol_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_idx = 7'd0; end_idx = 7'd1;
        launch();
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) step();
            env_v[k] = envelope; done_v[k] = done;
            // symbol 0 is in LOW here; symbol 1 must see the new word
            if (k == 4) begin
                @(negedge clk);
                mem_we = 1'b1; mem_addr = 2'd0; mem_wdata = 32'h0000_0001;
            end
            if (k == 5) begin
                @(negedge clk);
                mem_we = 1'b0;
            end
        end
        total++; if (env_v !== 19'h00606) begin bad++; $display("FAIL wr_env got=%h exp=00606", env_v); end
        total++; if (done_v !== 19'h10000) begin bad++; $display("FAIL wr_done got=%h exp=10000", done_v); end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        tick = 1'b1;
        test_reset();
        test_basic();
        test_prescale();
        test_loop();
        test_abort();
        test_zero();
        test_reset_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
